// File: rtl/bcd_stopwatch4_pkg.sv
// Shared definitions for the 4-digit BCD stopwatch: FSM state encoding,
// digit limit and divider counter sizing.
package bcd_stopwatch4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Counter width able to hold 0..n-1 (never narrower than one bit).
    function automatic int div_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_stopwatch4_key_debounce.sv
// Push-key conditioner: two-flop synchroniser, stable-level counter and a
// one-cycle pulse on every accepted press (released -> pressed). Releases
// are debounced the same way but produce no pulse.
module bcd_stopwatch4_key_debounce #(
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    import bcd_stopwatch4_pkg::*;

    localparam int                CNT_W    = div_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the raw key into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b0;
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            level_r <= sync2_r;
            cnt_r   <= '0;
            press_r <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1'b1);
            press_r <= 1'b0;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/bcd_stopwatch4.sv
// 4-digit BCD stopwatch / event counter feeding a multiplexed 7-segment
// scanner. Two debounced keys drive an IDLE/RUN/PAUSE FSM; a tick divider
// advances a packed BCD value; a free-running divider strobes scan_en.
module bcd_stopwatch4 #(
    parameter int TICK_DIV     = 50_000,
    parameter int SCAN_DIV     = 12_500,
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic        Clk,
    input  logic        Aclr,
    input  logic        key_ss,
    input  logic        key_clr,
    output logic [15:0] bcd,
    output logic        scan_en,
    output logic        running,
    output logic        wrap
);
    import bcd_stopwatch4_pkg::*;

    localparam int                 TICK_W    = div_width(TICK_DIV);
    localparam int                 SCAN_W    = div_width(SCAN_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic              ss_press_s;
    logic              clr_press_s;
    sw_state_t         state_r;
    logic              running_r;
    logic [TICK_W-1:0] tick_r;
    logic              tick_hit_s;
    logic [SCAN_W-1:0] scan_cnt_r;
    logic              scan_en_r;
    logic [15:0]       bcd_r;
    logic [15:0]       bcd_inc_s;
    logic              bcd_carry_s;
    logic              wrap_r;

    bcd_stopwatch4_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ss_key (
        .clk   (Clk),
        .rst_n (Aclr),
        .key   (key_ss),
        .press (ss_press_s)
    );

    bcd_stopwatch4_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr_key (
        .clk   (Clk),
        .rst_n (Aclr),
        .key   (key_clr),
        .press (clr_press_s)
    );

    // Run-control FSM; clear overrides a simultaneous start/stop press.
    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
        end else if (clr_press_s) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
        end else if (ss_press_s) begin
            case (state_r)
                ST_IDLE, ST_PAUSE: begin
                    state_r   <= ST_RUN;
                    running_r <= 1'b1;
                end
                ST_RUN: begin
                    state_r   <= ST_PAUSE;
                    running_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end else begin
            state_r   <= state_r;
            running_r <= running_r;
        end
    end

    assign tick_hit_s = (tick_r == TICK_LAST);

    // Ripple-carry BCD increment; any digit at or above 9 rolls to 0.
    always_comb begin
        logic carry_v;
        bcd_inc_s = bcd_r;
        carry_v   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!carry_v) begin
                bcd_inc_s[4*i +: 4] = bcd_r[4*i +: 4];
            end else if (bcd_r[4*i +: 4] >= BCD_MAX) begin
                bcd_inc_s[4*i +: 4] = 4'd0;
                carry_v             = 1'b1;
            end else begin
                bcd_inc_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd1;
                carry_v             = 1'b0;
            end
        end
        bcd_carry_s = carry_v;
    end

    // Tick divider and count value: advance in RUN, hold phase in PAUSE,
    // zero on clear.
    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            tick_r <= '0;
            bcd_r  <= 16'h0000;
            wrap_r <= 1'b0;
        end else if (clr_press_s) begin
            tick_r <= '0;
            bcd_r  <= 16'h0000;
            wrap_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            if (tick_hit_s) begin
                tick_r <= '0;
                bcd_r  <= bcd_inc_s;
                wrap_r <= bcd_carry_s;
            end else begin
                tick_r <= tick_r + TICK_W'(1'b1);
                wrap_r <= 1'b0;
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

    // Free-running scan strobe, independent of the FSM.
    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            scan_cnt_r <= '0;
            scan_en_r  <= 1'b0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            scan_en_r  <= 1'b1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1'b1);
            scan_en_r  <= 1'b0;
        end
    end

    assign bcd     = bcd_r;
    assign scan_en = scan_en_r;
    assign running = running_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_bcd_stopwatch4.sv
// Self-checking bench for bcd_stopwatch4 with short dividers. A behavioural
// reference (integer count value, sample windows for the keys) runs beside
// the DUT and is compared on the falling clock edge.
module tb_bcd_stopwatch4;

    localparam int TD = 4;
    localparam int SD = 3;
    localparam int DB = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic        Clk     = 1'b0;
    logic        Aclr    = 1'b0;
    logic        key_ss  = 1'b0;
    logic        key_clr = 1'b0;
    logic [15:0] bcd;
    logic        scan_en;
    logic        running;
    logic        wrap;

    int n_checks = 0;
    int n_errors = 0;

    bcd_stopwatch4 #(.TICK_DIV(TD), .SCAN_DIV(SD), .DEBOUNCE_CYC(DB)) dut (
        .Clk     (Clk),
        .Aclr    (Aclr),
        .key_ss  (key_ss),
        .key_clr (key_clr),
        .bcd     (bcd),
        .scan_en (scan_en),
        .running (running),
        .wrap    (wrap)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    int          m_val = 0;
    int          m_phase = 0;
    int          m_mode = M_IDLE;
    int          m_scan_phase = 0;
    logic        m_scan = 1'b0;
    logic        m_wrap = 1'b0;
    logic [1:0]  m_ss_pipe = 2'b00;
    logic [1:0]  m_clr_pipe = 2'b00;
    logic [DB-1:0] m_ss_hist = '0;
    logic [DB-1:0] m_clr_hist = '0;
    logic        m_ss_acc = 1'b0;
    logic        m_clr_acc = 1'b0;
    logic        m_ss_evt = 1'b0;
    logic        m_clr_evt = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Level is accepted once the last DB samples all disagree with it.
    function automatic void deb_step(input logic samp, inout logic [DB-1:0] hist,
                                     inout logic acc, output logic evt);
        hist = {hist[DB-2:0], samp};
        evt  = 1'b0;
        if (hist == {DB{~acc}}) begin
            evt = ~acc;
            acc = ~acc;
        end
    endfunction

    always @(posedge Clk or negedge Aclr) begin : ref_model
        int v_val, v_phase, v_mode, v_sp;
        logic v_scan, v_wrap, s_evt, c_evt, v_sacc, v_cacc;
        logic [DB-1:0] v_sh, v_ch;
        if (!Aclr) begin
            m_val <= 0; m_phase <= 0; m_mode <= M_IDLE; m_scan_phase <= 0;
            m_scan <= 1'b0; m_wrap <= 1'b0;
            m_ss_pipe <= 2'b00; m_clr_pipe <= 2'b00;
            m_ss_hist <= '0; m_clr_hist <= '0;
            m_ss_acc <= 1'b0; m_clr_acc <= 1'b0;
            m_ss_evt <= 1'b0; m_clr_evt <= 1'b0;
        end else begin
            v_val = m_val; v_phase = m_phase; v_mode = m_mode; v_sp = m_scan_phase;
            v_scan = (v_sp == SD - 1);
            v_sp   = (v_sp + 1) % SD;
            v_wrap = 1'b0;
            if (m_clr_evt) begin
                v_mode = M_IDLE; v_val = 0; v_phase = 0;
            end else begin
                if (v_mode == M_RUN) begin
                    if (v_phase == TD - 1) begin
                        v_phase = 0;
                        v_wrap  = (v_val == 9999);
                        v_val   = (v_val + 1) % 10000;
                    end else begin
                        v_phase = v_phase + 1;
                    end
                end
                if (m_ss_evt) v_mode = (v_mode == M_RUN) ? M_PAUSE : M_RUN;
            end
            v_sh = m_ss_hist; v_ch = m_clr_hist; v_sacc = m_ss_acc; v_cacc = m_clr_acc;
            deb_step(m_ss_pipe[1], v_sh, v_sacc, s_evt);
            deb_step(m_clr_pipe[1], v_ch, v_cacc, c_evt);
            m_val <= v_val; m_phase <= v_phase; m_mode <= v_mode; m_scan_phase <= v_sp;
            m_scan <= v_scan; m_wrap <= v_wrap;
            m_ss_pipe <= {m_ss_pipe[0], key_ss}; m_clr_pipe <= {m_clr_pipe[0], key_clr};
            m_ss_hist <= v_sh; m_clr_hist <= v_ch; m_ss_acc <= v_sacc; m_clr_acc <= v_cacc;
            m_ss_evt <= s_evt; m_clr_evt <= c_evt;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int k;
        Aclr = 1'b0; key_ss = 1'b0; key_clr = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if (bcd !== 16'h0000 || running !== 1'b0 || scan_en !== 1'b0 || wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: bcd=%h run=%b scan=%b wrap=%b, expected 0000/0/0/0", bcd, running, scan_en, wrap);
        end
        Aclr = 1'b1;
        key_ss = 1'b1;
        k = 0;
        while (running !== 1'b1 && k < 30) begin @(negedge Clk); k++; end
        n_checks++;
        if (running !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_start: running=%b, expected 1 within 30 cycles", running);
        end
        key_ss = 1'b0;
        repeat (15) @(negedge Clk);
        n_checks++;
        if (bcd !== to_bcd(m_val) || bcd === 16'h0000) begin
            n_errors++;
            $display("FAIL reset_midrun: bcd=%h, expected %h (nonzero)", bcd, to_bcd(m_val));
        end
        #2 Aclr = 1'b0;
        #1;
        n_checks++;
        if (bcd !== 16'h0000 || running !== 1'b0 || scan_en !== 1'b0 || wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: bcd=%h run=%b scan=%b wrap=%b, expected 0000/0/0/0", bcd, running, scan_en, wrap);
        end
        @(negedge Clk);
        Aclr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk);
            n_checks++;
            if (scan_en !== ((i % 3) == 2)) begin
                n_errors++;
                $display("FAIL scan_phase[%0d]: scan_en=%b, expected %b", i, scan_en, ((i % 3) == 2));
            end
        end
    endtask

    task automatic test_bounce();
        int rises;
        logic prev;
        rises = 0;
        prev  = running;
        key_ss = 1'b0;
        for (int i = 0; i < 34; i++) begin
            if (i < 20 && (i % 2) == 0) key_ss = ~key_ss;
            if (i == 20) key_ss = 1'b1;
            if (i == 32) key_ss = 1'b0;
            @(negedge Clk);
            if (running === 1'b1 && prev !== 1'b1) rises++;
            prev = running;
            n_checks++;
            if (bcd !== to_bcd(m_val) || running !== (m_mode == M_RUN)) begin
                n_errors++;
                $display("FAIL bounce_model[%0d]: bcd=%h run=%b, expected %h/%b", i, bcd, running, to_bcd(m_val), (m_mode == M_RUN));
            end
        end
        repeat (12) begin
            @(negedge Clk);
            if (running === 1'b1 && prev !== 1'b1) rises++;
            prev = running;
        end
        n_checks++;
        if (running !== 1'b1 || rises != 1) begin
            n_errors++;
            $display("FAIL bounce_single_run: running=%b rises=%0d, expected 1 and 1", running, rises);
        end
    endtask

    task automatic test_count();
        int k;
        logic [15:0] frozen;
        key_clr = 1'b1;
        k = 0;
        while (running !== 1'b0 && k < 30) begin @(negedge Clk); k++; end
        key_clr = 1'b0;
        repeat (10) @(negedge Clk);
        n_checks++;
        if (bcd !== 16'h0000 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL count_clear: bcd=%h run=%b, expected 0000/0", bcd, running);
        end
        key_ss = 1'b1;
        k = 0;
        while (running !== 1'b1 && k < 30) begin @(negedge Clk); k++; end
        key_ss = 1'b0;
        repeat (40) @(negedge Clk);
        n_checks++;
        if (bcd !== 16'h0010) begin
            n_errors++;
            $display("FAIL count_40: bcd=%h, expected 0010", bcd);
        end
        key_ss = 1'b1;
        k = 0;
        while (running !== 1'b0 && k < 30) begin @(negedge Clk); k++; end
        key_ss = 1'b0;
        frozen = bcd;
        n_checks++;
        if (running !== 1'b0 || frozen !== to_bcd(m_val)) begin
            n_errors++;
            $display("FAIL pause_enter: run=%b bcd=%h, expected 0/%h", running, frozen, to_bcd(m_val));
        end
        repeat (20) begin
            @(negedge Clk);
            n_checks++;
            if (bcd !== frozen) begin
                n_errors++;
                $display("FAIL pause_frozen: bcd=%h, expected %h", bcd, frozen);
            end
        end
        key_ss = 1'b1;
        k = 0;
        while (running !== 1'b1 && k < 30) begin @(negedge Clk); k++; end
        key_ss = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            n_checks++;
            if (bcd !== to_bcd(m_val) || running !== 1'b1) begin
                n_errors++;
                $display("FAIL resume_phase[%0d]: bcd=%h run=%b, expected %h/1", i, bcd, running, to_bcd(m_val));
            end
        end
    endtask

    task automatic test_carry_wrap();
        int k;
        k = 0;
        while (bcd !== 16'h0999 && k < 5000) begin @(negedge Clk); k++; end
        n_checks++;
        if (bcd !== 16'h0999) begin
            n_errors++;
            $display("FAIL reach_0999: bcd=%h, expected 0999", bcd);
        end
        k = 0;
        while (bcd === 16'h0999 && k < 6) begin @(negedge Clk); k++; end
        n_checks++;
        if (bcd !== 16'h1000 || wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL carry_1000: bcd=%h wrap=%b, expected 1000/0", bcd, wrap);
        end
        k = 0;
        while (bcd !== 16'h9999 && k < 40000) begin @(negedge Clk); k++; end
        n_checks++;
        if (bcd !== 16'h9999) begin
            n_errors++;
            $display("FAIL reach_9999: bcd=%h, expected 9999", bcd);
        end
        k = 0;
        while (bcd === 16'h9999 && k < 6) begin @(negedge Clk); k++; end
        n_checks++;
        if (bcd !== 16'h0000 || wrap !== 1'b1 || m_wrap !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_edge: bcd=%h wrap=%b, expected 0000/1", bcd, wrap);
        end
        @(negedge Clk);
        n_checks++;
        if (wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_pulse: wrap=%b, expected 0", wrap);
        end
        k = 0;
        while (bcd === 16'h0000 && k < 6) begin @(negedge Clk); k++; end
        n_checks++;
        if (bcd !== 16'h0001 || running !== 1'b1) begin
            n_errors++;
            $display("FAIL after_wrap: bcd=%h run=%b, expected 0001/1", bcd, running);
        end
    endtask

    task automatic test_clear_priority();
        n_checks++;
        if (running !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_precond: running=%b, expected 1", running);
        end
        key_ss = 1'b1;
        key_clr = 1'b1;
        repeat (12) @(negedge Clk);
        n_checks++;
        if (running !== 1'b0 || bcd !== 16'h0000 || m_mode != M_IDLE) begin
            n_errors++;
            $display("FAIL clear_priority: run=%b bcd=%h, expected 0/0000", running, bcd);
        end
        key_ss = 1'b0;
        key_clr = 1'b0;
        repeat (12) @(negedge Clk);
        n_checks++;
        if (running !== 1'b0 || bcd !== 16'h0000) begin
            n_errors++;
            $display("FAIL clear_release: run=%b bcd=%h, expected 0/0000", running, bcd);
        end
    endtask

    task automatic test_random();
        int ss_hold, clr_hold;
        logic bad;
        ss_hold = 0;
        clr_hold = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge Clk);
            bad = 1'b0;
            for (int j = 0; j < 4; j++) if (bcd[4*j +: 4] > 4'd9) bad = 1'b1;
            n_checks++;
            if (bad) begin
                n_errors++;
                $display("FAIL digit_legal[%0d]: bcd=%h, expected all nibbles <= 9", i, bcd);
            end
            n_checks++;
            if (bcd !== to_bcd(m_val) || running !== (m_mode == M_RUN) ||
                wrap !== m_wrap || scan_en !== m_scan) begin
                n_errors++;
                $display("FAIL random_model[%0d]: bcd=%h run=%b wrap=%b scan=%b, expected %h/%b/%b/%b",
                         i, bcd, running, wrap, scan_en, to_bcd(m_val), (m_mode == M_RUN), m_wrap, m_scan);
            end
            if (ss_hold == 0) begin
                key_ss  = ($urandom_range(0, 1) == 1);
                ss_hold = $urandom_range(1, 12);
            end else begin
                ss_hold--;
            end
            if (clr_hold == 0) begin
                key_clr  = ($urandom_range(0, 7) == 0);
                clr_hold = $urandom_range(1, 16);
            end else begin
                clr_hold--;
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_count();
        test_carry_wrap();
        test_clear_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
